// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Measures the sig_in period in clk_50 cycles, averaged over
//               2^AVG_LOG2 periods, with a ready/valid result handshake,
//               a no-signal timeout and a sticky overrun flag.
//               Optional phase measurement against ref_in is enabled by
//               defining the macro FREQ_METER_PHASE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module freq_meter #(
    parameter int          CNT_W    = 24,
    parameter int          AVG_LOG2 = 2,
    parameter logic [31:0] TIMEOUT  = 32'd5000000
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             ref_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] phase,
    output logic             nosig,
    output logic             overrun
);

    localparam int               ACC_W     = CNT_W + AVG_LOG2;
    localparam int               EC_W      = AVG_LOG2 + 1;
    localparam logic [EC_W-1:0]  LAST_EDGE = EC_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [31:0]      TO_LAST   = TIMEOUT - 32'd1;

    // IDLE: not armed; MEASURE: armed, nothing pending; HOLD: armed, result pending
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;

    logic              sig_meta;
    logic              sig_sync;
    logic              sig_prev;
    logic              sig_rise;

    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [EC_W-1:0]   edge_cnt;
    logic [31:0]       to_cnt;

    logic              armed;
    logic              done;
    logic              timeout;
    logic              load;
    logic              drop;
    logic              valid_next;

    assign sig_rise   = sig_sync & ~sig_prev;
    assign acc_sum    = acc + ACC_W'(cnt);
    assign armed      = (state != IDLE);
    assign done       = armed & sig_rise & (edge_cnt == LAST_EDGE);
    assign timeout    = ~sig_rise & (to_cnt == TO_LAST);
    // A completed result is taken if the slot is empty or being emptied now
    assign load       = done & (~meas_valid | meas_ready);
    assign drop       = done & meas_valid & ~meas_ready;
    assign valid_next = load | (meas_valid & ~meas_ready);

    // State register
    always_ff @(posedge clk_50) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next state: arm on first edge, track pending result, fall back on timeout
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (sig_rise) state_d = valid_next ? HOLD : MEASURE;
            end
            MEASURE, HOLD: begin
                if (timeout) state_d = IDLE;
                else         state_d = valid_next ? HOLD : MEASURE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronizer, timeout watchdog, period accumulation and result registers
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            sig_meta   <= 1'b0;
            sig_sync   <= 1'b0;
            sig_prev   <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            edge_cnt   <= '0;
            to_cnt     <= '0;
            nosig      <= 1'b0;
            meas_valid <= 1'b0;
            period     <= '0;
            overrun    <= 1'b0;
        end else begin
            sig_meta <= sig_in;
            sig_sync <= sig_meta;
            sig_prev <= sig_sync;

            // Watchdog fires once per silent stretch, then holds
            if (sig_rise) begin
                to_cnt <= '0;
                nosig  <= 1'b0;
            end else begin
                if (to_cnt != TIMEOUT) to_cnt <= to_cnt + 32'd1;
                if (timeout)           nosig  <= 1'b1;
            end

            if (!armed) begin
                if (sig_rise) begin
                    cnt      <= CNT_W'(1);
                    acc      <= '0;
                    edge_cnt <= '0;
                end
            end else if (timeout) begin
                cnt      <= '0;
                acc      <= '0;
                edge_cnt <= '0;
            end else if (sig_rise) begin
                // The completing edge also starts the next averaging window
                cnt <= CNT_W'(1);
                if (done) begin
                    acc      <= '0;
                    edge_cnt <= '0;
                end else begin
                    acc      <= acc_sum;
                    edge_cnt <= edge_cnt + EC_W'(1);
                end
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            meas_valid <= valid_next;
            if (load)                     period  <= CNT_W'(acc_sum >> AVG_LOG2);
            if (drop)                     overrun <= 1'b1;
            else if (meas_valid && meas_ready && !done) overrun <= 1'b0;
        end
    end

`ifdef FREQ_METER_PHASE_EN
    logic             ref_meta;
    logic             ref_sync;
    logic             ref_prev;
    logic             ref_rise;
    logic [CNT_W-1:0] ph_cnt;
    logic [CNT_W-1:0] ph_next;

    assign ref_rise = ref_sync & ~ref_prev;
    // Value the phase counter takes this cycle; this is what a sig_in edge latches
    assign ph_next  = ref_rise ? '0 : ((ph_cnt == CNT_MAX) ? ph_cnt : ph_cnt + CNT_W'(1));

    // Reference synchronizer, phase counter and phase result register
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            ref_meta <= 1'b0;
            ref_sync <= 1'b0;
            ref_prev <= 1'b0;
            ph_cnt   <= '0;
            phase    <= '0;
        end else begin
            ref_meta <= ref_in;
            ref_sync <= ref_meta;
            ref_prev <= ref_sync;
            ph_cnt   <= ph_next;
            if (load) phase <= ph_next;
        end
    end
`else
    logic unused_ref;
    assign unused_ref = ref_in;
    assign phase      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_meter
// Description : Directed self-checking bench for freq_meter (TIMEOUT=1000).
//               Expected phase depends on FREQ_METER_PHASE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_freq_meter;

    localparam int CNT_W    = 24;
    localparam int REF_LEAD = 50;
`ifdef FREQ_METER_PHASE_EN
    localparam int PH_EXP = 50;
`else
    localparam int PH_EXP = 0;
`endif

    logic             clk_50 = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             ref_in = 1'b0;
    logic             meas_ready = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] phase;
    logic             nosig;
    logic             overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t_edge = 0;
    int ref_en = 0;
    int base   = 0;

    // accepted-result log
    int               n_acc  = 0;
    int               last_t = 0;
    int               prev_t = 0;
    logic [CNT_W-1:0] acc_period = '0;
    logic [CNT_W-1:0] acc_phase  = '0;

    freq_meter #(
        .CNT_W   (CNT_W),
        .AVG_LOG2(2),
        .TIMEOUT (32'd1000)
    ) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .ref_in    (ref_in),
        .meas_ready(meas_ready),
        .meas_valid(meas_valid),
        .period    (period),
        .phase     (phase),
        .nosig     (nosig),
        .overrun   (overrun)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    // Log each handshake (valid & ready seen just after the falling edge)
    always @(negedge clk_50) begin
        #1;
        if (meas_valid && meas_ready) begin
            n_acc      = n_acc + 1;
            acc_period = period;
            acc_phase  = phase;
            prev_t     = last_t;
            last_t     = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One sig_in period of n cycles, rising edge first; ref_in optionally
    // rises REF_LEAD cycles before the next sig_in edge
    task automatic gen_period(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50);
            if (i == 0) t_edge = cyc;
            sig_in = (i < n / 2);
            ref_in = (ref_en != 0) && (i >= n - REF_LEAD) && (i < n - REF_LEAD + 10);
        end
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk_50);
        rst_n      = 1'b0;
        sig_in     = 1'b0;
        ref_in     = 1'b0;
        meas_ready = rdy;
        ref_en     = 0;
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        // ---- reset state
        do_reset(1'b1);
        check("rst_valid",   32'(meas_valid), 32'd0);
        check("rst_period",  32'(period),     32'd0);
        check("rst_phase",   32'(phase),      32'd0);
        check("rst_nosig",   32'(nosig),      32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);

        // ---- steady 200-cycle input, ready high, ref leading by 50
        ref_en = 1;
        base   = n_acc;
        repeat (9) gen_period(200);
        check("s200_count",    32'(n_acc - base), 32'd2);
        check("s200_period",   32'(acc_period),   32'd200);
        check("s200_interval", 32'(last_t - prev_t), 32'd800);
        check("s200_phase",    32'(acc_phase),    32'(PH_EXP));

        // ---- averaging and truncation
        do_reset(1'b1);
        base = n_acc;
        gen_period(199); gen_period(201); gen_period(199); gen_period(201);
        gen_period(100);
        check("avg200_count",  32'(n_acc - base), 32'd1);
        check("avg200_period", 32'(acc_period),   32'd200);
        gen_period(100); gen_period(100); gen_period(101);
        gen_period(200);
        check("avg100_count",  32'(n_acc - base), 32'd2);
        check("avg100_period", 32'(acc_period),   32'd100);

        // ---- overrun: second result completes while the first is held
        do_reset(1'b0);
        base = n_acc;
        repeat (4) gen_period(200);
        repeat (4) gen_period(100);
        gen_period(200);
        check("ovr_valid",   32'(meas_valid), 32'd1);
        check("ovr_period",  32'(period),     32'd200);
        check("ovr_flag",    32'(overrun),    32'd1);
        meas_ready = 1'b1;
        @(negedge clk_50);
        check("ovr_acc_period", 32'(acc_period),   32'd200);
        check("ovr_acc_count",  32'(n_acc - base), 32'd1);
        check("ovr_valid_drop", 32'(meas_valid),   32'd0);
        check("ovr_flag_clear", 32'(overrun),      32'd0);

        // ---- timeout after two edges, then restart
        do_reset(1'b1);
        base = n_acc;
        gen_period(200);
        gen_period(200);
        while (cyc < t_edge + 1002) @(negedge clk_50);
        check("to_nosig_before", 32'(nosig), 32'd0);
        @(negedge clk_50);
        check("to_nosig_after",  32'(nosig), 32'd1);
        check("to_no_result",    32'(n_acc - base), 32'd0);
        check("to_valid",        32'(meas_valid),   32'd0);
        gen_period(200);
        check("to_nosig_clear",  32'(nosig), 32'd0);
        repeat (3) gen_period(200);
        check("to_four_edges",   32'(n_acc - base), 32'd0);
        gen_period(200);
        check("to_five_edges",   32'(n_acc - base), 32'd1);
        check("to_period",       32'(acc_period),   32'd200);

        // ---- reset pulse while holding a result
        do_reset(1'b0);
        repeat (5) gen_period(200);
        check("hold_valid", 32'(meas_valid), 32'd1);
        @(negedge clk_50);
        rst_n = 1'b0;
        @(negedge clk_50);
        rst_n = 1'b1;
        check("hrst_valid",   32'(meas_valid), 32'd0);
        check("hrst_period",  32'(period),     32'd0);
        check("hrst_phase",   32'(phase),      32'd0);
        check("hrst_nosig",   32'(nosig),      32'd0);
        check("hrst_overrun", 32'(overrun),    32'd0);
        meas_ready = 1'b1;
        base = n_acc;
        repeat (4) gen_period(200);
        check("hrst_rearm_four", 32'(n_acc - base), 32'd0);
        gen_period(200);
        check("hrst_rearm_five", 32'(n_acc - base), 32'd1);
        check("hrst_period2",    32'(acc_period),   32'd200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
